// File: rtl/cavlc_block_encoder.sv
// cavlc_block_encoder
//   Encodes one residual block of up to 16 zig-zag ordered 9-bit levels into
//   a stream of CAVLC codewords, one per cw_valid/cw_ready handshake, in the
//   order coeff_token, trailing-one signs, level prefix/suffix, total_zeros,
//   run_before. coeff_token and total_zeros codes come from external tables.
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   blk_valid/blk_ready     block handshake (ready only while idle)
//   coeff_in                16 x 9-bit levels, k=0 in the low bits
//   maxNumCoeff, nC         block size (16/15/4) and context for coeff_token
//   ct_* out / ct_code,len  coeff_token table address and returned code
//   tz_* out / tz_code,len  total_zeros table address and returned code
//   cw_valid/cw_ready       codeword handshake toward the packer
//   cw_bits, cw_len         right-aligned codeword and its length
//   end_of_blk_enc          one-cycle pulse after the last codeword is taken
module cavlc_block_encoder (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [143:0] coeff_in,
  input  logic [4:0]   maxNumCoeff,
  input  logic [4:0]   nC,
  output logic [4:0]   ct_TotalCoeff,
  output logic [1:0]   ct_TrailingOnes,
  output logic [4:0]   ct_nC,
  input  logic [15:0]  ct_code,
  input  logic [4:0]   ct_len,
  output logic [3:0]   tz_TotalCoeff,
  output logic [3:0]   tz_total_zeros,
  output logic [4:0]   tz_maxNumCoeff,
  input  logic [8:0]   tz_code,
  input  logic [3:0]   tz_len,
  output logic         cw_valid,
  input  logic         cw_ready,
  output logic [15:0]  cw_bits,
  output logic [4:0]   cw_len,
  output logic         end_of_blk_enc
);

  typedef enum logic [3:0] {IDLE, SCAN, CT, T1, LPRE, LSUF, TZ, RUN, DONE} state_t;
  typedef struct packed { logic [3:0] pre; logic [11:0] suf; logic [3:0] sz; } lvlEnc_t;
  typedef struct packed { logic [4:0] len; logic [15:0] bits; } cw_t;

  state_t            state, nxt;
  logic signed [8:0] coeffR [16];
  logic signed [8:0] lv [16];     // nonzero levels, highest k first
  logic [3:0]        rb [16];     // zeros following each stored level
  logic [3:0]        scanK;
  logic              scanDone;
  logic [4:0]        tc;
  logic [1:0]        t1;
  logic              t1Stop;
  logic [3:0]        tz;
  logic [4:0]        mnc;
  logic [4:0]        nCR;
  logic [1:0]        t1Idx;
  logic [4:0]        lvlIdx;
  logic [2:0]        sL;
  logic [11:0]       sufBitsR;
  logic [3:0]        sufLenR;
  logic [4:0]        runIdx;
  logic [3:0]        zerosLeft;

  assign ct_TotalCoeff   = tc;
  assign ct_TrailingOnes = t1;
  assign ct_nC           = nCR;
  assign tz_TotalCoeff   = tc[3:0];
  assign tz_total_zeros  = tz;
  assign tz_maxNumCoeff  = mnc;

  function automatic logic [10:0] absLvl(input logic signed [8:0] l);
    logic [10:0] x;
    x = {{2{l[8]}}, l};
    return l[8] ? 11'(-x) : x;
  endfunction

  function automatic lvlEnc_t levelEnc(input logic signed [8:0] l, input logic [2:0] sl,
                                       input logic sub2);
    lvlEnc_t     e;
    logic [10:0] mag, lc, lim;
    mag = absLvl(l);
    lc  = l[8] ? (mag << 1) - 11'd1 : (mag << 1) - 11'd2;
    if (sub2) lc = lc - 11'd2;
    lim = 11'd15 << sl;
    e = '0;
    if (sl == 3'd0) begin
      if (lc < 11'd14) begin
        e.pre = lc[3:0];
      end else if (lc < 11'd30) begin
        e.pre = 4'd14; e.sz = 4'd4; e.suf = 12'(lc - 11'd14);
      end else begin
        e.pre = 4'd15; e.sz = 4'd12; e.suf = 12'(lc - 11'd30);
      end
    end else if (lc < lim) begin
      e.pre = 4'(lc >> sl);
      e.sz  = {1'b0, sl};
      e.suf = 12'(lc & ~(11'h7FF << sl));
    end else begin
      e.pre = 4'd15; e.sz = 4'd12; e.suf = 12'(lc - lim);
    end
    return e;
  endfunction

  function automatic logic [2:0] nextSl(input logic [10:0] mag, input logic [2:0] sl);
    logic [2:0] s;
    s = (sl == 3'd0) ? 3'd1 : sl;
    if (mag > (11'd3 << (s - 3'd1)) && s < 3'd6) s = s + 3'd1;
    return s;
  endfunction

  function automatic cw_t runCode(input logic [3:0] run, input logic [2:0] zl);
    cw_t c;
    c.len  = 5'd3;
    c.bits = '0;
    case (zl)
      3'd1: begin c.len = 5'd1; c.bits = (run == 4'd0) ? 16'd1 : 16'd0; end
      3'd2: begin
        c.len  = (run == 4'd0) ? 5'd1 : 5'd2;
        c.bits = (run < 4'd2) ? 16'd1 : 16'd0;
      end
      3'd3: begin c.len = 5'd2; c.bits = 16'(4'd3 - run); end
      3'd4: begin
        if (run < 4'd3) begin c.len = 5'd2; c.bits = 16'(4'd3 - run); end
        else c.bits = (run == 4'd3) ? 16'd1 : 16'd0;
      end
      3'd5: begin
        if (run < 4'd2) begin c.len = 5'd2; c.bits = 16'(4'd3 - run); end
        else c.bits = 16'(4'd5 - run);
      end
      3'd6: begin
        case (run)
          4'd0:    begin c.len = 5'd2; c.bits = 16'd3; end
          4'd1:    c.bits = 16'd0;
          4'd2:    c.bits = 16'd1;
          4'd3:    c.bits = 16'd3;
          4'd4:    c.bits = 16'd2;
          4'd5:    c.bits = 16'd5;
          default: c.bits = 16'd4;
        endcase
      end
      default: begin
        if (run < 4'd7) c.bits = 16'(4'd7 - run);
        else begin c.len = 5'(run) - 5'd3; c.bits = 16'd1; end
      end
    endcase
    return c;
  endfunction

  // Next-codeword selection: each state names the nominal successor, then the
  // empty stages are folded away in order (levels -> TZ -> RUN -> DONE) so the
  // following codeword is loaded on the same edge that accepts the current one.
  logic signed [8:0] curLvl;
  logic [4:0]        encIdx, rIdx;
  logic [2:0]        encSl, sLInit, sLAfter;
  logic [1:0]        t1Nxt;
  logic [3:0]        rZl;
  lvlEnc_t           enc;
  cw_t               rc;

  assign curLvl = coeffR[scanK];

  always_comb begin
    sLInit  = (tc > 5'd10 && t1 != 2'd3) ? 3'd1 : 3'd0;
    sLAfter = nextSl(absLvl(lv[lvlIdx[3:0]]), sL);
    if (state == CT || state == T1) begin
      encIdx = {3'b0, t1};
      encSl  = sLInit;
    end else begin
      encIdx = lvlIdx + 5'd1;
      encSl  = sLAfter;
    end
    enc   = levelEnc(lv[encIdx[3:0]], encSl, (encIdx == {3'b0, t1}) && (t1 != 2'd3));
    t1Nxt = (state == CT) ? 2'd0 : t1Idx + 2'd1;
    if (state == RUN) begin
      rIdx = runIdx + 5'd1;
      rZl  = zerosLeft - rb[runIdx[3:0]];
    end else begin
      rIdx = '0;
      rZl  = tz;
    end
    rc = runCode(rb[rIdx[3:0]], (rZl > 4'd7) ? 3'd7 : rZl[2:0]);

    nxt = DONE;
    case (state)
      CT:      nxt = (tc == 5'd0) ? DONE : (t1 != 2'd0) ? T1 : LPRE;
      T1:      nxt = ({1'b0, t1Idx} + 3'd1 < {1'b0, t1}) ? T1 : LPRE;
      LPRE:    nxt = (sufLenR != 4'd0) ? LSUF : LPRE;
      LSUF:    nxt = LPRE;
      TZ:      nxt = RUN;
      RUN:     nxt = RUN;
      default: nxt = DONE;
    endcase
    if (nxt == LPRE && encIdx >= tc) nxt = TZ;
    if (nxt == TZ && tc == mnc) nxt = RUN;
    if (nxt == RUN && !((rIdx + 5'd1 < tc) && rZl != 4'd0)) nxt = DONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      blk_ready      <= 1'b1;
      cw_valid       <= 1'b0;
      cw_bits        <= '0;
      cw_len         <= '0;
      end_of_blk_enc <= 1'b0;
      scanK          <= '0;
      scanDone       <= 1'b0;
      tc             <= '0;
      t1             <= '0;
      t1Stop         <= 1'b0;
      tz             <= '0;
      mnc            <= '0;
      nCR            <= '0;
      t1Idx          <= '0;
      lvlIdx         <= '0;
      sL             <= '0;
      sufBitsR       <= '0;
      sufLenR        <= '0;
      runIdx         <= '0;
      zerosLeft      <= '0;
      for (int unsigned k = 0; k < 16; k++) begin
        coeffR[k] <= '0;
        lv[k]     <= '0;
        rb[k]     <= '0;
      end
    end else begin
      case (state)
        IDLE: if (blk_valid) begin
          for (int unsigned k = 0; k < 16; k++) begin
            coeffR[k] <= coeff_in[9*k +: 9];
            rb[k]     <= '0;
          end
          mnc       <= maxNumCoeff;
          nCR       <= nC;
          scanK     <= 4'(maxNumCoeff - 5'd1);
          scanDone  <= 1'b0;
          tc        <= '0;
          t1        <= '0;
          t1Stop    <= 1'b0;
          tz        <= '0;
          state     <= SCAN;
          blk_ready <= 1'b0;
        end
        SCAN: begin
          if (!scanDone) begin
            if (curLvl != 9'sd0) begin
              lv[tc[3:0]] <= curLvl;
              tc          <= tc + 5'd1;
              if (!t1Stop && t1 != 2'd3 && (curLvl == 9'sd1 || curLvl == -9'sd1))
                t1 <= t1 + 2'd1;
              else
                t1Stop <= 1'b1;
            end else if (tc != 5'd0) begin
              rb[tc[3:0] - 4'd1] <= rb[tc[3:0] - 4'd1] + 4'd1;
              tz                 <= tz + 4'd1;
            end
            if (scanK == 4'd0) scanDone <= 1'b1;
            else               scanK    <= scanK - 4'd1;
          end else begin
            // Totals are settled; the coeff_token table is addressed this cycle.
            state    <= CT;
            cw_valid <= 1'b1;
            cw_bits  <= ct_code;
            cw_len   <= ct_len;
          end
        end
        DONE: begin
          end_of_blk_enc <= 1'b0;
          state          <= IDLE;
          blk_ready      <= 1'b1;
        end
        default: if (cw_valid && cw_ready) begin
          state <= nxt;
          case (nxt)
            T1: begin
              t1Idx   <= t1Nxt;
              cw_bits <= {15'b0, lv[{2'b0, t1Nxt}][8]};
              cw_len  <= 5'd1;
            end
            LPRE: begin
              lvlIdx   <= encIdx;
              sL       <= encSl;
              sufBitsR <= enc.suf;
              sufLenR  <= enc.sz;
              cw_bits  <= 16'd1;
              cw_len   <= {1'b0, enc.pre} + 5'd1;
            end
            LSUF: begin
              cw_bits <= {4'b0, sufBitsR};
              cw_len  <= {1'b0, sufLenR};
            end
            TZ: begin
              cw_bits <= {7'b0, tz_code};
              cw_len  <= {1'b0, tz_len};
            end
            RUN: begin
              runIdx    <= rIdx;
              zerosLeft <= rZl;
              cw_bits   <= rc.bits;
              cw_len    <= rc.len;
            end
            default: begin
              cw_valid       <= 1'b0;
              cw_bits        <= '0;
              cw_len         <= '0;
              end_of_blk_enc <= 1'b1;
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_block_encoder.sv
// tb_cavlc_block_encoder
//   Directed bench for cavlc_block_encoder. Provides simple coeff_token and
//   total_zeros tables, applies hand-built blocks and compares the emitted
//   codeword list, table addresses, latency and end pulse to hand-computed values.
module tb_cavlc_block_encoder;

  logic         clk;
  logic         reset_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [143:0] coeff_in;
  logic [4:0]   maxNumCoeff;
  logic [4:0]   nC;
  logic [4:0]   ct_TotalCoeff;
  logic [1:0]   ct_TrailingOnes;
  logic [4:0]   ct_nC;
  logic [15:0]  ct_code;
  logic [4:0]   ct_len;
  logic [3:0]   tz_TotalCoeff;
  logic [3:0]   tz_total_zeros;
  logic [4:0]   tz_maxNumCoeff;
  logic [8:0]   tz_code;
  logic [3:0]   tz_len;
  logic         cw_valid;
  logic         cw_ready;
  logic [15:0]  cw_bits;
  logic [4:0]   cw_len;
  logic         end_of_blk_enc;

  cavlc_block_encoder dut (
    .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .coeff_in(coeff_in), .maxNumCoeff(maxNumCoeff), .nC(nC),
    .ct_TotalCoeff(ct_TotalCoeff), .ct_TrailingOnes(ct_TrailingOnes), .ct_nC(ct_nC),
    .ct_code(ct_code), .ct_len(ct_len),
    .tz_TotalCoeff(tz_TotalCoeff), .tz_total_zeros(tz_total_zeros),
    .tz_maxNumCoeff(tz_maxNumCoeff), .tz_code(tz_code), .tz_len(tz_len),
    .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_bits(cw_bits), .cw_len(cw_len),
    .end_of_blk_enc(end_of_blk_enc)
  );

  // Stand-in tables: TotalCoeff 0 -> (1,1); otherwise an 8-bit code {T1,TC,1}.
  // total_zeros -> 9-bit code {1,TC,TZ}.
  always_comb begin
    ct_code = (ct_TotalCoeff == 5'd0) ? 16'd1 : 16'({ct_TrailingOnes, ct_TotalCoeff, 1'b1});
    ct_len  = (ct_TotalCoeff == 5'd0) ? 5'd1 : 5'd8;
    tz_code = {1'b1, tz_TotalCoeff, tz_total_zeros};
    tz_len  = 4'd9;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int expQ[$];
  logic signed [8:0] tLv [16];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int cw(input int len, input int bits);
    return (len << 16) | bits;
  endfunction

  function automatic int ctExp(input int tc, input int t1);
    return (tc == 0) ? cw(1, 1) : cw(8, t1 * 64 + tc * 2 + 1);
  endfunction

  function automatic int tzExp(input int tc, input int tz);
    return cw(9, 256 + tc * 16 + tz);
  endfunction

  task automatic clearLv();
    for (int k = 0; k < 16; k++) tLv[k] = '0;
    expQ.delete();
  endtask

  task automatic startBlock(input int mnc);
    for (int k = 0; k < 16; k++) coeff_in[9*k +: 9] = tLv[k];
    maxNumCoeff = 5'(mnc);
    blk_valid   = 1'b1;
    @(negedge clk);
    blk_valid   = 1'b0;
  endtask

  task automatic runBlock(input string name, input int mnc, input int eTc,
                          input int eT1, input int eTz);
    int cnt;
    bit done;
    int got[$];
    check({name, "_rdy"}, int'(blk_ready), 1);
    startBlock(mnc);
    cnt = 0;
    while (!cw_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check({name, "_lat"}, cnt, mnc + 1);
    check({name, "_ctTC"}, int'(ct_TotalCoeff), eTc);
    check({name, "_ctT1"}, int'(ct_TrailingOnes), eT1);
    check({name, "_tzTZ"}, int'(tz_total_zeros), eTz);
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (end_of_blk_enc) done = 1'b1;
      else begin
        if (cw_valid && cw_ready) got.push_back(cw(int'(cw_len), int'(cw_bits)));
        @(negedge clk);
      end
    end
    check({name, "_eob"}, int'(done), 1);
    check({name, "_eobVld"}, int'(cw_valid), 0);
    check({name, "_ncw"}, got.size(), expQ.size());
    for (int i = 0; i < got.size() && i < expQ.size(); i++)
      check($sformatf("%s_cw%0d", name, i), got[i], expQ[i]);
    @(negedge clk);
    check({name, "_eobPulse"}, int'(end_of_blk_enc), 0);
    check({name, "_rdyBack"}, int'(blk_ready), 1);
  endtask

  initial begin
    reset_n = 1'b0; blk_valid = 1'b0; cw_ready = 1'b1;
    coeff_in = '0; maxNumCoeff = 5'd16; nC = 5'd0;
    repeat (2) @(negedge clk);
    check("rst_rdy", int'(blk_ready), 1);
    check("rst_vld", int'(cw_valid), 0);
    check("rst_bits", int'(cw_bits), 0);
    check("rst_len", int'(cw_len), 0);
    check("rst_eob", int'(end_of_blk_enc), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // all-zero block: only the coeff_token
    clearLv();
    expQ.push_back(ctExp(0, 0));
    runBlock("t1zero", 16, 0, 0, 0);

    // k0=3, k1=1: one trailing one, one level
    clearLv();
    tLv[0] = 9'sd3; tLv[1] = 9'sd1;
    nC = 5'd5;
    expQ.push_back(ctExp(2, 1));
    expQ.push_back(cw(1, 0));
    expQ.push_back(cw(3, 1));
    expQ.push_back(tzExp(2, 0));
    runBlock("t2", 16, 2, 1, 0);
    check("t2_nC", int'(ct_nC), 5);
    nC = 5'd0;

    // k0=200: escape prefix 15 with 12-bit suffix 366
    clearLv();
    tLv[0] = 9'sd200;
    expQ.push_back(ctExp(1, 0));
    expQ.push_back(cw(16, 1));
    expQ.push_back(cw(12, 366));
    expQ.push_back(tzExp(1, 0));
    runBlock("t3", 16, 1, 0, 0);

    // k0=1, k5=1: two trailing ones, total_zeros 4, one run_before
    clearLv();
    tLv[0] = 9'sd1; tLv[5] = 9'sd1;
    expQ.push_back(ctExp(2, 2));
    expQ.push_back(cw(1, 0));
    expQ.push_back(cw(1, 0));
    expQ.push_back(tzExp(2, 4));
    expQ.push_back(cw(3, 0));
    runBlock("t4", 16, 2, 2, 4);

    // 16 x +2: suffixLength starts at 1, TZ skipped
    clearLv();
    for (int k = 0; k < 16; k++) tLv[k] = 9'sd2;
    expQ.push_back(ctExp(16, 0));
    expQ.push_back(cw(1, 1));
    expQ.push_back(cw(1, 0));
    for (int k = 1; k < 16; k++) begin
      expQ.push_back(cw(2, 1));
      expQ.push_back(cw(1, 0));
    end
    runBlock("t5", 16, 16, 0, 0);

    // maxNumCoeff=4, negative levels, k5 ignored, run_before with zerosLeft=1
    clearLv();
    tLv[0] = -9'sd1; tLv[2] = -9'sd2; tLv[5] = 9'sd7;
    expQ.push_back(ctExp(2, 0));
    expQ.push_back(cw(2, 1));
    expQ.push_back(cw(1, 1));
    expQ.push_back(cw(1, 1));
    expQ.push_back(tzExp(2, 1));
    expQ.push_back(cw(1, 0));
    runBlock("t7", 4, 2, 0, 1);
    check("t7_tzMnc", int'(tz_maxNumCoeff), 4);

    // maxNumCoeff=15, k0=4, k1=10: 4-bit suffix then suffixLength jumps to 2
    clearLv();
    tLv[0] = 9'sd4; tLv[1] = 9'sd10;
    expQ.push_back(ctExp(2, 0));
    expQ.push_back(cw(15, 1));
    expQ.push_back(cw(4, 2));
    expQ.push_back(cw(2, 1));
    expQ.push_back(cw(2, 2));
    expQ.push_back(tzExp(2, 0));
    runBlock("t8", 15, 2, 0, 0);

    // stall on the coeff_token, then reset mid-block
    clearLv();
    tLv[0] = 9'sd3; tLv[1] = 9'sd1;
    startBlock(16);
    cw_ready = 1'b0;
    for (int c = 0; c < 100 && !cw_valid; c++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_vld", int'(cw_valid), 1);
      check("stall_cw", cw(int'(cw_len), int'(cw_bits)), ctExp(2, 1));
      @(negedge clk);
    end
    cw_ready = 1'b1;
    @(negedge clk);
    check("stall_sign", cw(int'(cw_len), int'(cw_bits)), cw(1, 0));
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_vld", int'(cw_valid), 0);
    check("mid_rst_rdy", int'(blk_ready), 1);
    check("mid_rst_len", int'(cw_len), 0);
    check("mid_rst_eob", int'(end_of_blk_enc), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_vld", int'(cw_valid), 0);

    // clean block after the reset
    clearLv();
    expQ.push_back(ctExp(0, 0));
    runBlock("after", 16, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
